pipe_stage_skid_reg: RTL and testbench
======================================

// Module: pipe_stage_skid_reg
// PURPOSE
//  Parametrised inter-stage pipeline register for the 5-stage MIPS core.
//  Replaces hard-wired EN/CLR stage registers with a valid/ready handshake and a 2-entry skid buffer.
//  Back-pressure is therefore fully registered and breaks the combinational stall path.
//  Sits between any two stages (IF/ID, ID/EX, ...); the payload is a packed bus (e.g. {Instr, PCPlus4}).
// PARAMETERS
//  DATA_W   32  payload width in bits (>=1)
//  BUBBLE   0   DATA_W-bit value driven on out_data when empty or flushed (0 = sll $0,$0,0 NOP)
//  STALL_W  16  width of the saturating stall-cycle counter (>=1)
// PORTS
//  CLK          in   1        clock, rising edge
//  RST          in   1        reset, asynchronous, active-low
//  FLUSH        in   1        synchronous flush; discards held and incoming payloads
//  in_valid     in   1        upstream payload valid
//  in_ready     out  1        stage can accept; registered (no comb path from out_ready)
//  in_data      in   DATA_W   upstream payload
//  out_valid    out  1        out_data holds a live payload
//  out_ready    in   1        downstream accepts this cycle
//  out_data     out  DATA_W   payload to next stage
//  occupancy    out  2        entries held: 0, 1 or 2
//  stall_cnt    out  STALL_W  cycles with out_valid & !out_ready, saturating
// BEHAVIOUR
//  Reset: out_valid=0, in_ready=1, out_data=BUBBLE, occupancy=0, stall_cnt=0; the skid entry is invalid.
//  Transfers: accept = in_valid & in_ready; issue = out_valid & out_ready.
//  Storage: main reg (drives out_data) and skid reg; state EMPTY/ONE/FULL = occupancy 0/1/2.
//  EMPTY: accept -> ONE, main<=in_data (1-cycle latency, no bypass).
//  ONE:
//   accept & issue  -> ONE, main<=in_data.
//   accept & !issue -> FULL, skid<=in_data.
//   !accept & issue -> EMPTY.
//  FULL (in_ready=0):
//   issue  -> ONE, main<=skid.
//   !issue -> hold.
//  in_ready is registered: it is 1 in the next cycle iff the next state is not FULL.
//  Ordering: strict FIFO. No payload is duplicated or dropped except by FLUSH.
//  FLUSH=1 (highest priority over accept and issue):
//   next state EMPTY; main and skid <= BUBBLE; in_ready<=1.
//   in_data presented in the same cycle is discarded.
//   An issue in the same cycle still completes downstream, because out_data was valid at that edge.
//  out_data = BUBBLE whenever out_valid=0; downstream may rely on this.
//  stall_cnt increments on out_valid & !out_ready. It holds at 2^STALL_W-1, is unaffected by FLUSH, and clears only on RST.
//  Reset mid-transfer: all state drops immediately (asynchronous); no partial payload survives.
//  in_data is ignored when in_valid=0; out_ready is ignored when out_valid=0.
// STRUCTURE
//  Shared package mips_pipe_pkg:
//   localparam NOP_INSTR = 32'h0000_0000;
//   occupancy state encodings ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2.
//  One sub-module, sat_counter #(W), for stall_cnt; reusable by the hazard unit's perf counters.
//  The datapath stays inline: two DATA_W registers plus a 2:1 mux onto main.
// TESTING
//  T1 Reset: RST=0 with in_valid=1 -> out_valid=0, out_data=BUBBLE, in_ready=1, occupancy=0, stall_cnt=0.
//  T2 Streaming: in_valid=1 and out_ready=1 every cycle, data 1,2,3.
//     -> out_data 1,2,3 one cycle later each; occupancy stays 1; in_ready stays 1.
//  T3 Back-pressure: out_ready=0 while pushing A,B.
//     -> occupancy 2, in_ready=0, C held upstream.
//     Then out_ready=1 -> A, B, C in order with no loss; stall_cnt counts the stalled cycles exactly.
//  T4 Flush in FULL with in_valid=1 (data D):
//     -> next cycle out_valid=0, out_data=BUBBLE, occupancy=0, in_ready=1; D never appears.
//  T5 Flush and issue in the same cycle:
//     -> the head payload is seen by the sink at that edge, then the stage is empty.
//  T6 STALL_W=2 with out_ready=0 for 6 cycles -> stall_cnt=3 and holds.
//     Also: asynchronous RST pulse mid-burst clears all outputs without a clock edge.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline stage registers.
package mips_pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones until cleared or reset.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer.
// in_ready is registered, so back-pressure never forms a combinational path upstream.
module pipe_stage_skid_reg
  import mips_pipe_pkg::*;
#(
  parameter int unsigned       DATA_W  = 32,
  parameter logic [DATA_W-1:0] BUBBLE  = DATA_W'(NOP_INSTR),
  parameter int unsigned       STALL_W = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               FLUSH,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [1:0]         occupancy,
  output logic [STALL_W-1:0] stall_cnt
);

  occ_state_t        state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic              accept, issue;

  always_comb begin
    accept  = in_valid & in_ready_q;
    issue   = (state_q != ST_EMPTY) & out_ready;
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (FLUSH) begin
      // An issue this cycle already completed downstream off main_q at the edge.
      state_d = ST_EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (accept && issue) begin
            main_d = in_data;
          end else if (accept) begin
            state_d = ST_FULL;
            skid_d  = in_data;
          end else if (issue) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (issue) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end

    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_EMPTY;
      main_q     <= BUBBLE;
      skid_q     <= BUBBLE;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign out_valid = (state_q != ST_EMPTY);
  // main_q keeps a stale payload after the last issue; mask it so consumers see a NOP.
  assign out_data  = out_valid ? main_q : BUBBLE;
  assign in_ready  = in_ready_q;
  assign occupancy = state_q;

  sat_counter #(
    .W(STALL_W)
  ) u_stall_cnt (
    .CLK  (CLK),
    .RST  (RST),
    .clr_i(1'b0),
    .inc_i(out_valid & ~out_ready),
    .cnt_o(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Self-checking bench: randomized and directed traffic against a queue-based model of the stage.
module tb_pipe_stage_skid_reg;

  localparam logic [31:0] BUBBLE     = 32'hDEAD_BEEF;
  localparam logic [7:0]  BUBBLE2    = 8'hA5;
  localparam int unsigned STALL_MAX  = 65535;
  localparam int unsigned STALL2_MAX = 3;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        FLUSH = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_data = '0;

  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;
  logic        in_ready2, out_valid2;
  logic [7:0]  out_data2;
  logic [1:0]  occ2;
  logic [1:0]  stall2;
  logic [51:0] act_vec;

  int unsigned n_assert = 0;
  int unsigned n_fail = 0;

  // Model: the stage is a FIFO of at most two payloads.
  logic [31:0] mq[$];
  logic [31:0] src[$];
  logic [31:0] sink[$];
  logic [31:0] exp_sink[$];
  bit          exp_ready = 1'b1;
  int unsigned exp_stall = 0;
  int unsigned exp_stall2 = 0;

  pipe_stage_skid_reg #(
    .DATA_W (32),
    .BUBBLE (BUBBLE),
    .STALL_W(16)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .FLUSH    (FLUSH),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  pipe_stage_skid_reg #(
    .DATA_W (8),
    .BUBBLE (BUBBLE2),
    .STALL_W(2)
  ) dut2 (
    .CLK      (CLK),
    .RST      (RST),
    .FLUSH    (FLUSH),
    .in_valid (in_valid),
    .in_ready (in_ready2),
    .in_data  (in_data[7:0]),
    .out_valid(out_valid2),
    .out_ready(out_ready),
    .out_data (out_data2),
    .occupancy(occ2),
    .stall_cnt(stall2)
  );

  always #5 CLK = ~CLK;

  assign act_vec = {out_valid, out_data, occupancy, in_ready, stall_cnt};

  function automatic logic [51:0] exp_vec();
    logic [31:0] d;
    d = (mq.size() != 0) ? mq[0] : BUBBLE;
    return {mq.size() != 0, d, 2'(mq.size()), exp_ready, 16'(exp_stall)};
  endfunction

  task automatic model_reset();
    mq.delete();
    src.delete();
    sink.delete();
    exp_sink.delete();
    exp_ready  = 1'b1;
    exp_stall  = 0;
    exp_stall2 = 0;
  endtask

  // One clock: present src head upstream, record what the DUT issues, advance the model.
  task automatic cycle();
    bit acc, iss, stl;
    in_valid = (src.size() != 0);
    in_data  = in_valid ? src[0] : $urandom();
    if (out_valid && out_ready) sink.push_back(out_data);
    acc = in_valid && exp_ready;
    iss = (mq.size() != 0) && out_ready;
    stl = (mq.size() != 0) && !out_ready;
    @(posedge CLK);
    if (stl && exp_stall < STALL_MAX) exp_stall++;
    if (stl && exp_stall2 < STALL2_MAX) exp_stall2++;
    if (iss) exp_sink.push_back(mq[0]);
    if (FLUSH) begin
      mq.delete();
    end else begin
      if (iss) void'(mq.pop_front());
      if (acc) mq.push_back(in_data);
    end
    if (acc) void'(src.pop_front());
    exp_ready = (mq.size() < 2);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b0; in_valid = 1'b1; in_data = 32'h1234_5678; out_ready = 1'b0; FLUSH = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    n_assert++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_assert++;
    if (out_data !== BUBBLE) begin n_fail++; $display("FAIL reset_out_data: got %h want %h", out_data, BUBBLE); end
    n_assert++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_assert++;
    if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
    n_assert++;
    if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
    n_assert++;
    if (out_data2 !== BUBBLE2) begin n_fail++; $display("FAIL reset_out_data2: got %h want %h", out_data2, BUBBLE2); end
    in_valid = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    model_reset();
  endtask

  task automatic test_streaming();
    out_ready = 1'b1; FLUSH = 1'b0;
    sink.delete(); exp_sink.delete();
    src = '{32'd1, 32'd2, 32'd3};
    for (int k = 1; k <= 3; k++) begin
      cycle();
      n_assert++;
      if (out_data !== 32'(k) || occupancy !== 2'd1 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_step%0d: got data=%0d occ=%0d rdy=%b want data=%0d occ=1 rdy=1",
                 k, out_data, occupancy, in_ready, k);
      end
      n_assert++;
      if (act_vec !== exp_vec()) begin n_fail++; $display("FAIL stream_model: got %h want %h", act_vec, exp_vec()); end
    end
    cycle();
    n_assert++;
    if (sink.size() != 3 || sink[0] !== 32'd1 || sink[1] !== 32'd2 || sink[2] !== 32'd3) begin
      n_fail++; $display("FAIL stream_order: got %p want '{1,2,3}", sink);
    end
  endtask

  task automatic test_back_pressure();
    int unsigned s0;
    s0 = exp_stall;
    out_ready = 1'b0; sink.delete(); exp_sink.delete();
    src = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003};
    repeat (3) cycle();
    n_assert++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hA0A0_0001) begin
      n_fail++;
      $display("FAIL bp_full: got occ=%0d rdy=%b data=%h want occ=2 rdy=0 data=a0a00001",
               occupancy, in_ready, out_data);
    end
    n_assert++;
    if (stall_cnt !== 16'(s0 + 2)) begin n_fail++; $display("FAIL bp_stall: got %0d want %0d", stall_cnt, s0 + 2); end
    out_ready = 1'b1;
    repeat (4) cycle();
    n_assert++;
    if (sink.size() != 3 || sink[0] !== 32'hA0A0_0001 || sink[1] !== 32'hB0B0_0002 ||
        sink[2] !== 32'hC0C0_0003) begin
      n_fail++; $display("FAIL bp_order: got %p want '{a0a00001,b0b00002,c0c00003}", sink);
    end
    n_assert++;
    if (stall_cnt !== 16'(s0 + 2) || occupancy !== 2'd0) begin
      n_fail++; $display("FAIL bp_drain: got stall=%0d occ=%0d want stall=%0d occ=0", stall_cnt, occupancy, s0 + 2);
    end
  endtask

  task automatic test_flush_full();
    out_ready = 1'b0;
    src = '{32'h0D00_0000, 32'h0D00_0001, 32'h0DDD_DDDD};
    repeat (2) cycle();
    FLUSH = 1'b1;
    cycle();
    FLUSH = 1'b0;
    src.delete();
    n_assert++;
    if (out_valid !== 1'b0 || out_data !== BUBBLE || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_full: got v=%b data=%h occ=%0d rdy=%b want v=0 data=%h occ=0 rdy=1",
               out_valid, out_data, occupancy, in_ready, BUBBLE);
    end
    // Flush while the stage is accepting: the incoming payload must vanish too.
    src = '{32'h0600_0000, 32'h0800_0000};
    cycle();
    FLUSH = 1'b1;
    cycle();
    FLUSH = 1'b0;
    n_assert++;
    if (occupancy !== 2'd0 || out_data !== BUBBLE) begin
      n_fail++; $display("FAIL flush_accept: got occ=%0d data=%h want occ=0 data=%h", occupancy, out_data, BUBBLE);
    end
    out_ready = 1'b1; sink.delete();
    repeat (3) cycle();
    n_assert++;
    if (sink.size() != 0) begin n_fail++; $display("FAIL flush_leak: got %0d issued want 0", sink.size()); end
    n_assert++;
    if (act_vec !== exp_vec()) begin n_fail++; $display("FAIL flush_model: got %h want %h", act_vec, exp_vec()); end
  endtask

  task automatic test_flush_issue();
    out_ready = 1'b0;
    src = '{32'h0E0E_0E0E, 32'h0F0F_0F0F};
    repeat (2) cycle();
    sink.delete(); exp_sink.delete();
    out_ready = 1'b1; FLUSH = 1'b1;
    cycle();
    FLUSH = 1'b0;
    n_assert++;
    if (sink.size() != 1 || sink[0] !== 32'h0E0E_0E0E) begin
      n_fail++; $display("FAIL flush_issue_head: got %p want '{0e0e0e0e}", sink);
    end
    n_assert++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      n_fail++; $display("FAIL flush_issue_empty: got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy);
    end
  endtask

  task automatic test_random();
    int bad;
    sink.delete(); exp_sink.delete();
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      FLUSH     = ($urandom_range(0, 15) == 0);
      if (src.size() < 3 && $urandom_range(0, 2) != 0) src.push_back($urandom());
      cycle();
      n_assert++;
      if (act_vec !== exp_vec()) begin
        n_fail++; $display("FAIL rand_main cyc%0d: got %h want %h", i, act_vec, exp_vec());
      end
      n_assert++;
      if ({out_valid2, occ2, in_ready2, stall2} !== {mq.size() != 0, 2'(mq.size()), exp_ready, 2'(exp_stall2)}) begin
        n_fail++; $display("FAIL rand_narrow cyc%0d: got v=%b occ=%0d rdy=%b stall=%0d", i, out_valid2, occ2,
                           in_ready2, stall2);
      end
      n_assert++;
      if (out_data2 !== ((mq.size() != 0) ? mq[0][7:0] : BUBBLE2)) begin
        n_fail++; $display("FAIL rand_narrow_data cyc%0d: got %h", i, out_data2);
      end
    end
    FLUSH = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && (src.size() != 0 || mq.size() != 0); i++) cycle();
    n_assert++;
    if (occupancy !== 2'd0 || mq.size() != 0) begin
      n_fail++; $display("FAIL rand_drain_timeout: got occ=%0d want 0", occupancy);
    end
    bad = -1;
    if (sink.size() == exp_sink.size()) begin
      for (int i = 0; i < sink.size(); i++) if (sink[i] !== exp_sink[i] && bad < 0) bad = i;
    end
    n_assert++;
    if (sink.size() != exp_sink.size() || bad >= 0) begin
      n_fail++; $display("FAIL rand_order: got %0d items (first bad %0d) want %0d items", sink.size(), bad,
                         exp_sink.size());
    end
  endtask

  task automatic test_stall_sat();
    in_valid = 1'b0; FLUSH = 1'b0;
    RST = 1'b0;
    #3;
    RST = 1'b1;
    model_reset();
    out_ready = 1'b0;
    src = '{32'h0000_005A};
    repeat (7) cycle();
    n_assert++;
    if (stall2 !== 2'd3) begin n_fail++; $display("FAIL sat_stall2: got %0d want 3", stall2); end
    n_assert++;
    if (stall_cnt !== 16'd6) begin n_fail++; $display("FAIL sat_stall16: got %0d want 6", stall_cnt); end
    repeat (2) cycle();
    n_assert++;
    if (stall2 !== 2'd3 || stall_cnt !== 16'd8) begin
      n_fail++; $display("FAIL sat_hold: got stall2=%0d stall=%0d want 3 and 8", stall2, stall_cnt);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    src = '{32'h1111_1111, 32'h2222_2222};
    repeat (3) cycle();
    #2;
    RST = 1'b0;
    #1;
    n_assert++;
    if (out_valid !== 1'b0 || out_data !== BUBBLE || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_rst_outs: got v=%b data=%h occ=%0d rdy=%b", out_valid, out_data, occupancy, in_ready);
    end
    n_assert++;
    if (stall_cnt !== 16'd0 || stall2 !== 2'd0 || out_valid2 !== 1'b0) begin
      n_fail++; $display("FAIL async_rst_cnt: got stall=%0d stall2=%0d v2=%b", stall_cnt, stall2, out_valid2);
    end
    model_reset();
    in_valid = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush_full();
    test_flush_issue();
    test_random();
    test_stall_sat();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
